// File: rtl/d_latch_pkg.sv
// Shared constants and helpers for the byte-enabled data register.
package d_latch_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEFAULT_DATA_W = 16;

  function automatic int calc_nbytes(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/byte_lane_reg.sv
// One 8-bit lane of the register: async reset to rst_val, loads d on clk when en is high.
// Latency one clk; no backpressure, the lane always accepts a write when enabled.
module byte_lane_reg
  import d_latch_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [BYTE_W-1:0] d,
  input  logic [BYTE_W-1:0] rst_val,
  output logic [BYTE_W-1:0] q
);

  // An X enable falls through to hold, so an unknown strobe never corrupts the lane.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/d_latch.sv
// Edge-triggered data register with per-byte write enables (not a latch, despite the name).
// Latency one clk from D/byteena to Q; no backpressure, every enabled lane is written each edge.
module d_latch
  import d_latch_pkg::*;
#(
  parameter int                DATA_W    = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [calc_nbytes(DATA_W)-1:0]  byteena,
  input  logic [DATA_W-1:0]               D,
  output logic [DATA_W-1:0]               Q
);

  localparam int NBYTES = calc_nbytes(DATA_W);

  generate
    if (DATA_W <= 0) begin : g_bad_width
      $error("d_latch: DATA_W must be greater than 0");
    end
    if ((DATA_W % BYTE_W) != 0) begin : g_bad_align
      $error("d_latch: DATA_W must be a multiple of 8");
    end
  endgenerate

  // Each lane drives its own slice of Q straight from its flops.
  genvar i;
  generate
    for (i = 0; i < NBYTES; i++) begin : g_lane
      byte_lane_reg u_lane (
        .clk     (clk),
        .resetn  (resetn),
        .en      (byteena[i]),
        .d       (D[i*BYTE_W +: BYTE_W]),
        .rst_val (RESET_VAL[i*BYTE_W +: BYTE_W]),
        .q       (Q[i*BYTE_W +: BYTE_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_d_latch.sv
// Bench for d_latch: directed vector table, corner sequences, and random traffic vs a lane model.
module tb_d_latch;

  logic        clk;
  logic        resetn;
  logic [1:0]  byteena;
  logic [15:0] D;
  logic [15:0] Q;

  int checks   = 0;
  int failures = 0;

  d_latch dut (
    .clk     (clk),
    .resetn  (resetn),
    .byteena (byteena),
    .D       (D),
    .Q       (Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  be;
    logic [15:0] d;
    logic [15:0] q;
  } vec_t;

  vec_t vecs[6];

  // Reference model: two independent bytes, reset to zero.
  logic [7:0] model_b[2];

  function automatic logic [15:0] model_q();
    return {model_b[1], model_b[0]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: Q=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"full_write",  2'b11, 16'hAAAA, 16'hAAAA};
    vecs[1] = '{"upper_write", 2'b10, 16'hCCCC, 16'hCCAA};
    vecs[2] = '{"lower_write", 2'b01, 16'hF0F0, 16'hCCF0};
    vecs[3] = '{"hold_1",      2'b00, 16'h1234, 16'hCCF0};
    vecs[4] = '{"hold_2",      2'b00, 16'h1234, 16'hCCF0};
    vecs[5] = '{"hold_3",      2'b00, 16'h1234, 16'hCCF0};

    resetn  = 1'b0;
    byteena = 2'b00;
    D       = 16'h0000;
    #1;
    check("reset_initial", Q, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("reset_hold", Q, 16'h0000);
    end

    // Writes attempted while in reset must be ignored.
    @(negedge clk);
    byteena = 2'b11;
    D       = 16'hFFFF;
    @(posedge clk); #1;
    check("reset_blocks_write", Q, 16'h0000);

    // Release on a falling edge; the first rising edge must already write.
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      byteena = vecs[k].be;
      D       = vecs[k].d;
      @(posedge clk); #1;
      check(vecs[k].name, Q, vecs[k].q);
      @(negedge clk);
    end

    // Input activity between edges must not reach Q.
    byteena = 2'b11;
    D       = 16'h9999;
    #2;
    check("no_comb_path", Q, 16'hCCF0);
    byteena = 2'b00;
    D       = 16'h0000;
    @(posedge clk); #1;
    check("mid_cycle_ignored", Q, 16'hCCF0);

    // Asynchronous reset between edges, with a write pending.
    @(negedge clk);
    byteena = 2'b11;
    D       = 16'h5555;
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_immediate", Q, 16'h0000);
    @(posedge clk); #1;
    check("async_reset_overrides", Q, 16'h0000);
    @(posedge clk); #1;
    check("async_reset_stays", Q, 16'h0000);

    @(negedge clk);
    resetn  = 1'b1;
    byteena = 2'b11;
    D       = 16'hABCD;
    @(posedge clk); #1;
    check("first_write_after_reset", Q, 16'hABCD);

    // Unknown data on a disabled lane must leave it intact.
    @(negedge clk);
    byteena = 2'b01;
    D       = {8'hxx, 8'h5A};
    @(posedge clk); #1;
    check("x_data_masked_lane", Q, 16'hAB5A);
    @(negedge clk);
    byteena = 2'b00;
    D       = 16'hxxxx;
    @(posedge clk); #1;
    check("x_data_full_hold", Q, 16'hAB5A);

    // Random traffic with occasional async resets.
    model_b[0] = 8'h5A;
    model_b[1] = 8'hAB;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      byteena = 2'($urandom_range(0, 3));
      D       = 16'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        #2;
        resetn     = 1'b0;
        model_b[0] = 8'h00;
        model_b[1] = 8'h00;
        #1;
        check("rand_async_reset", Q, model_q());
      end else begin
        resetn = 1'b1;
      end
      @(posedge clk);
      if (resetn) begin
        for (int l = 0; l < 2; l++) begin
          if (byteena[l]) model_b[l] = D[l*8 +: 8];
        end
      end
      #1;
      check("rand_cycle", Q, model_q());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d_latch.md
D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the data width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter RESET_VAL, default all-zeros (DATA_W bits), giving the value Q takes during reset.
REQ-003 The block SHALL have a derived constant NBYTES = DATA_W/8, default 2, giving the number of byte lanes.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port byteena, input, NBYTES bits (default 2): per-byte write enable; bit i controls D/Q bits [8i+7:8i].
REQ-007 Port D, input, DATA_W bits (default 16): write data.
REQ-008 Port Q, output, DATA_W bits (default 16): registered data.

Function
REQ-009 Despite the module name, the block SHALL be an edge-triggered register; there SHALL be no level-sensitive latch behaviour, and synthesis SHALL infer no latches.
REQ-010 On each rising clk edge with resetn high, for each lane i with byteena[i]=1, Q lane i SHALL take D lane i.
REQ-011 On each rising clk edge with resetn high, for each lane i with byteena[i]=0, Q lane i SHALL hold its previous value.
REQ-012 Lanes SHALL be independent; any combination of byteena bits is legal, including all-zero (full hold) and all-one (full 16-bit write).
REQ-013 Write latency SHALL be one clock: a value sampled on edge N SHALL be visible on Q immediately after edge N and SHALL be stable until the next qualifying edge.
REQ-014 Q SHALL be driven directly from flops, with no combinational path from D, byteena or clk to Q.
REQ-015 Changes on D or byteena between rising edges SHALL have no effect on Q.
REQ-016 If D and byteena are unknown (X) but byteena is sampled 0 for a lane, that lane SHALL hold its value without corruption.

Reset
REQ-017 When resetn is low, Q SHALL become RESET_VAL immediately, without waiting for a clk edge; the default is 16'h0000.
REQ-018 While resetn is low, Q SHALL remain RESET_VAL regardless of clk, byteena or D.
REQ-019 If resetn falls mid-operation, it SHALL override any write in the same cycle.
REQ-020 Reset release (resetn rising) SHALL be synchronous to clk.
REQ-021 The first write after reset release SHALL take effect on the first rising edge at which resetn is sampled high.

Structure
REQ-022 A shared package d_latch_pkg SHALL hold the constants BYTE_W=8 and DEFAULT_DATA_W=16, plus a helper function computing NBYTES.
REQ-023 Each byte lane SHALL be implemented by one sub-module, byte_lane_reg, instantiated NBYTES times via a generate loop.
REQ-024 Each byte_lane_reg SHALL have ports clk, resetn, en, d[7:0], rst_val[7:0] and q[7:0].
REQ-025 The top level SHALL include elaboration-time checks that DATA_W is greater than 0 and divisible by 8.

Verification
REQ-026 Reset scenario: hold resetn=0 with byteena=2'b00 and D=16'h0000 while clk toggles (10 ns period) -> Q=16'h0000 throughout.
REQ-027 Full write: release resetn, then apply D=16'hAAAA with byteena=2'b11 -> Q=16'hAAAA after the next rising edge.
REQ-028 Upper-byte write: apply D=16'hCCCC with byteena=2'b10 -> Q=16'hCCAA after the next rising edge.
REQ-029 Lower-byte write: apply D=16'hF0F0 with byteena=2'b01 -> Q=16'hCCF0 after the next rising edge.
REQ-030 Hold: apply byteena=2'b00 with D=16'h1234 for 3 edges -> Q unchanged (16'hCCF0).
REQ-031 Asynchronous reset: assert resetn=0 between clk edges while Q=16'hCCF0 -> Q=16'h0000 before the next edge, and it stays 0 until resetn=1 and a write occurs.
